// File: rtl/sram_stream_reader_pkg.sv
// rtl/sram_stream_reader_pkg.sv - shared widths, types and FSM states for the SRAM burst reader
package sram_stream_reader_pkg;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 64;
   localparam int LEN_W  = ADDR_W + 1;

   typedef logic [ADDR_W-1:0] sram_addr_t;
   typedef logic [DATA_W-1:0] sram_data_t;
   typedef logic [LEN_W-1:0]  burst_len_t;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_e;
endpackage

// File: rtl/sram_stream_reader_if.sv
// rtl/sram_stream_reader_if.sv - command, SRAM read port and output stream of the burst reader
interface sram_stream_reader_if;
   import sram_stream_reader_pkg::*;

   logic       cmd_valid;
   logic       cmd_ready;
   sram_addr_t cmd_base;
   burst_len_t cmd_len;
   logic       csbn;
   sram_addr_t raddr;
   sram_data_t rdata;
   logic       out_valid;
   logic       out_ready;
   sram_data_t out_data;
   logic       out_last;
   logic       busy;

   modport master (
      input  cmd_valid, cmd_base, cmd_len, rdata, out_ready,
      output cmd_ready, csbn, raddr, out_valid, out_data, out_last, busy
   );

   modport slave (
      output cmd_valid, cmd_base, cmd_len, rdata, out_ready,
      input  cmd_ready, csbn, raddr, out_valid, out_data, out_last, busy
   );
endinterface

// File: rtl/sram_stream_reader_rd_fifo.sv
// rtl/sram_stream_reader_rd_fifo.sv - synchronous show-ahead FIFO holding returned words and last tags
module sram_stream_reader_rd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 65,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (pop_i) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
endmodule

// File: rtl/sram_stream_reader.sv
// rtl/sram_stream_reader.sv - credit-gated burst reader turning SRAM reads into a valid/ready stream
module sram_stream_reader
   import sram_stream_reader_pkg::*;
#(
   parameter int BUF_DEPTH = 4
) (
   input logic                  clk,
   input logic                  rst,
   sram_stream_reader_if.master bus
);
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);

   rd_state_e  state_q;
   sram_addr_t addr_q;
   sram_addr_t raddr_q;
   burst_len_t rem_q;
   logic       issue_q;
   logic       last_q;

   logic             issue;
   logic             pop;
   logic             buf_full;
   logic             buf_empty;
   logic [CNT_W-1:0] buf_count;
   logic [DATA_W:0]  head;
   logic [CNT_W:0]   used;
   logic [CNT_W:0]   room;

   sram_stream_reader_rd_fifo #(
      .DEPTH(BUF_DEPTH),
      .WIDTH(DATA_W + 1),
      .CNT_W(CNT_W)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (issue_q),
      .push_data_i({last_q, bus.rdata}),
      .pop_i      (pop),
      .head_o     (head),
      .count_o    (buf_count),
      .full_o     (buf_full),
      .empty_o    (buf_empty)
   );

   // A read issued now lands in the buffer next cycle, so the word being captured
   // this cycle still occupies a slot while a pop this cycle frees one.
   assign pop   = !buf_empty && bus.out_ready;
   assign used  = {1'b0, buf_count} + (CNT_W + 1)'(issue_q);
   assign room  = (CNT_W + 1)'(BUF_DEPTH) + (CNT_W + 1)'(pop);
   assign issue = (state_q == RUN) && (rem_q != '0) && (used < room);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         raddr_q <= '0;
         rem_q   <= '0;
         issue_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         issue_q <= issue;
         last_q  <= issue && (rem_q == burst_len_t'(1));
         if (issue) begin
            addr_q  <= addr_q + sram_addr_t'(1);
            raddr_q <= addr_q;
            rem_q   <= rem_q - burst_len_t'(1);
         end
         case (state_q)
            IDLE: begin
               if (bus.cmd_valid) begin
                  addr_q <= bus.cmd_base;
                  rem_q  <= bus.cmd_len;
                  if (bus.cmd_len != '0) begin
                     state_q <= RUN;
                  end
               end
            end
            RUN: begin
               if (issue && (rem_q == burst_len_t'(1))) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop && head[DATA_W]) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.csbn      = !issue;
   assign bus.raddr     = issue ? addr_q : raddr_q;
   assign bus.out_valid = !buf_empty;
   assign bus.out_data  = buf_empty ? '0 : head[DATA_W-1:0];
   assign bus.out_last  = !buf_empty && head[DATA_W];
   assign bus.cmd_ready = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);

   a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(issue_q && buf_full));
endmodule

// File: tb/tb_sram_stream_reader.sv
// tb/tb_sram_stream_reader.sv - scoreboard bench for the SRAM burst reader
module tb_sram_stream_reader;
   import sram_stream_reader_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   sram_stream_reader_if sif();

   sram_stream_reader #(.BUF_DEPTH(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(sif)
   );

   always #5 clk = ~clk;

   sram_data_t mem [4096];
   int checks = 0;
   int errors = 0;
   sram_addr_t addr_exp [$];
   sram_data_t dat_exp  [$];
   bit         last_exp [$];
   int         beats = 0;
   int         lasts = 0;
   int         rd_cnt = 0;
   bit         rand_ready = 1'b0;
   bit         stall_q = 1'b0;
   sram_data_t held_data;
   bit         held_last;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // SRAM model returns poison when the previous cycle had no read
   always @(posedge clk) begin
      sif.rdata <= !sif.csbn ? mem[sif.raddr] : 64'hDEAD_BEEF_0BAD_F00D;
   end

   always @(negedge clk) begin
      if (rst) begin
         stall_q = 1'b0;
      end else begin
         if (!sif.csbn) begin
            rd_cnt++;
            if (addr_exp.size() == 0) check_eq("spurious_read", 64'(sif.raddr), 64'hFFFF);
            else check_eq("raddr", 64'(sif.raddr), 64'(addr_exp.pop_front()));
         end
         if (stall_q) begin
            check_eq("stall_valid", 64'(sif.out_valid), 64'(1));
            check_eq("stall_data", sif.out_data, held_data);
            check_eq("stall_last", 64'(sif.out_last), 64'(held_last));
         end
         if (sif.out_valid && sif.out_ready) begin
            beats++;
            if (sif.out_last) lasts++;
            if (dat_exp.size() == 0) begin
               check_eq("spurious_beat", 64'(1), 64'(0));
            end else begin
               check_eq("beat_data", sif.out_data, dat_exp.pop_front());
               check_eq("beat_last", 64'(sif.out_last), 64'(last_exp.pop_front()));
            end
         end
         stall_q   = sif.out_valid && !sif.out_ready;
         held_data = sif.out_data;
         held_last = sif.out_last;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) sif.out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic push_exp(input sram_addr_t base, input int len);
      for (int i = 0; i < len; i++) begin
         sram_addr_t a;
         a = base + sram_addr_t'(i);
         addr_exp.push_back(a);
         dat_exp.push_back(mem[a]);
         last_exp.push_back(i == len - 1);
      end
   endtask

   task automatic start(input sram_addr_t base, input int len, input bit expect_it);
      tick();
      sif.cmd_valid = 1'b1;
      sif.cmd_base  = base;
      sif.cmd_len   = burst_len_t'(len);
      if (expect_it) push_exp(base, len);
      tick();
      sif.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while ((sif.busy || dat_exp.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      check_eq({tag, "_done"}, 64'(n < budget), 64'(1));
      check_eq({tag, "_addrq"}, 64'(addr_exp.size()), 64'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      int b0;
      int n;
      for (int k = 0; k < 4096; k++) mem[k] = 64'(k) * 64'h1111;
      sif.cmd_valid = 1'b0;
      sif.cmd_base  = '0;
      sif.cmd_len   = '0;
      sif.out_ready = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check_eq("rst_csbn", 64'(sif.csbn), 64'(1));
      check_eq("rst_raddr", 64'(sif.raddr), 64'(0));
      check_eq("rst_out_valid", 64'(sif.out_valid), 64'(0));
      check_eq("rst_out_last", 64'(sif.out_last), 64'(0));
      check_eq("rst_out_data", sif.out_data, 64'(0));
      check_eq("rst_cmd_ready", 64'(sif.cmd_ready), 64'(1));
      check_eq("rst_busy", 64'(sif.busy), 64'(0));
      tick();
      rst = 1'b0;

      // basic burst with cycle-exact timing
      tick();
      sif.out_ready = 1'b1;
      sif.cmd_valid = 1'b1;
      sif.cmd_base  = 12'h010;
      sif.cmd_len   = 13'd4;
      push_exp(12'h010, 4);
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 1) sif.cmd_valid = 1'b0;
         @(negedge clk);
         check_eq($sformatf("t1_csbn_c%0d", k), 64'(sif.csbn), 64'(!(k >= 1 && k <= 4)));
         check_eq($sformatf("t1_valid_c%0d", k), 64'(sif.out_valid), 64'(k >= 3 && k <= 6));
         check_eq($sformatf("t1_last_c%0d", k), 64'(sif.out_last), 64'(k == 6));
         check_eq($sformatf("t1_busy_c%0d", k), 64'(sif.busy), 64'(k <= 6));
      end
      wait_idle("t1", 20);

      start(12'hFFE, 4, 1'b1);
      wait_idle("wrap", 50);

      // backpressure: consumer stalls cycles 2..11
      tick();
      sif.out_ready = 1'b1;
      sif.cmd_valid = 1'b1;
      sif.cmd_base  = 12'h040;
      sif.cmd_len   = 13'd16;
      push_exp(12'h040, 16);
      r0 = rd_cnt;
      tick();
      sif.cmd_valid = 1'b0;
      tick();
      sif.out_ready = 1'b0;
      repeat (9) tick();
      check_eq("bp_csbn_held", 64'(sif.csbn), 64'(1));
      tick();
      check_eq("bp_reads_bounded", 64'((rd_cnt - r0) <= 4), 64'(1));
      check_eq("bp_reads_nonzero", 64'((rd_cnt - r0) > 0), 64'(1));
      sif.out_ready = 1'b1;
      wait_idle("bp", 200);

      // full-memory sweep with random backpressure
      b0 = lasts;
      rand_ready = 1'b1;
      start(12'h000, 4096, 1'b1);
      wait_idle("sweep", 30000);
      rand_ready = 1'b0;
      sif.out_ready = 1'b1;
      check_eq("sweep_one_last", 64'(lasts - b0), 64'(1));

      // zero-length command
      tick();
      r0 = rd_cnt;
      b0 = beats;
      sif.cmd_valid = 1'b1;
      sif.cmd_base  = 12'h123;
      sif.cmd_len   = 13'd0;
      tick();
      sif.cmd_valid = 1'b0;
      check_eq("len0_cmd_ready", 64'(sif.cmd_ready), 64'(1));
      check_eq("len0_busy", 64'(sif.busy), 64'(0));
      repeat (4) tick();
      check_eq("len0_no_reads", 64'(rd_cnt - r0), 64'(0));
      check_eq("len0_no_beats", 64'(beats - b0), 64'(0));

      // command while busy is dropped
      start(12'h300, 8, 1'b1);
      sif.cmd_valid = 1'b1;
      sif.cmd_base  = 12'h500;
      sif.cmd_len   = 13'd3;
      check_eq("busy_cmd_ready", 64'(sif.cmd_ready), 64'(0));
      tick();
      sif.cmd_valid = 1'b0;
      wait_idle("ignore", 100);

      // reset mid-burst after the fifth beat
      start(12'h200, 32, 1'b1);
      b0 = beats;
      n = 0;
      while ((beats - b0) < 5 && n < 100) begin
         tick();
         n++;
      end
      check_eq("rst_mid_reached", 64'(n < 100), 64'(1));
      rst = 1'b1;
      addr_exp.delete();
      dat_exp.delete();
      last_exp.delete();
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_mid_csbn", 64'(sif.csbn), 64'(1));
      check_eq("rst_mid_out_valid", 64'(sif.out_valid), 64'(0));
      check_eq("rst_mid_cmd_ready", 64'(sif.cmd_ready), 64'(1));
      start(12'h100, 2, 1'b1);
      wait_idle("post_rst", 50);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
